// File: rtl/sseg_scan_pwm.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_pwm
// Brief    : 4-digit common-anode 7-segment scan driver with 16-level PWM
//            brightness, per-digit blanking and a frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_pwm #(
    parameter int CNT_W = 18
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_in_n [3:0],
    input  logic [3:0] i_dig_en,
    input  logic [3:0] i_duty,
    output logic [3:0] o_an_n,
    output logic [7:0] o_sseg_n,
    output logic       o_frame
);

    generate
        if (CNT_W < 6) begin : g_cnt_w_check
            $fatal(1, "sseg_scan_pwm: CNT_W must be >= 6");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic             frame_q, frame_d;

    logic [1:0]       w_dig;
    logic [3:0]       w_phase;
    logic             w_lit;

    // Top two counter bits pick the digit, next four bits the PWM phase.
    always_comb begin
        w_dig   = cnt_q[CNT_W-1 -: 2];
        w_phase = cnt_q[CNT_W-3 -: 4];
        w_lit   = i_dig_en[w_dig] && ((i_duty == 4'hF) || (w_phase < i_duty));
        cnt_d   = cnt_q + 1'b1;
        an_d    = 4'hF;
        sseg_d  = 8'hFF;
        frame_d = (cnt_q == '0);
        if (w_lit) begin
            an_d   = ~(4'b0001 << w_dig);
            sseg_d = i_in_n[w_dig];
        end
    end

    // Anode and segment registers share one edge so digits never ghost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q   <= '0;
            an_q    <= 4'hF;
            sseg_q  <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
        end
    end

    assign o_an_n   = an_q;
    assign o_sseg_n = sseg_q;
    assign o_frame  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_pwm
// Brief    : Self-checking bench for sseg_scan_pwm (CNT_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_pwm;

    localparam int C_CNT_W = 8;
    localparam int C_FRAME = 256;
    localparam int C_SLOT  = 64;
    localparam int C_PHASE = 4;

    logic       clk;
    logic       rst;
    logic [7:0] in_n [3:0];
    logic [3:0] dig_en;
    logic [3:0] duty;
    logic [3:0] an_n;
    logic [7:0] sseg_n;
    logic       frame;

    int total = 0;
    int bad   = 0;

    sseg_scan_pwm #(.CNT_W(C_CNT_W)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_in_n   (in_n),
        .i_dig_en (dig_en),
        .i_duty   (duty),
        .o_an_n   (an_n),
        .o_sseg_n (sseg_n),
        .o_frame  (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in frame as a plain integer, digit and phase
    // by division, anode pattern from a lookup table.
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int         m_cnt  = 0;
    logic [3:0] e_an   = 4'hF;
    logic [7:0] e_sseg = 8'hFF;
    logic       e_fr   = 1'b0;
    bit         check_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        int  d, ph;
        bit  lit;
        if (rst) begin
            m_cnt  = 0;
            e_an   = 4'hF;
            e_sseg = 8'hFF;
            e_fr   = 1'b0;
        end else begin
            d   = m_cnt / C_SLOT;
            ph  = (m_cnt % C_SLOT) / C_PHASE;
            lit = dig_en[d] && (duty == 4'd15 || ph < int'(duty));
            e_an   = lit ? an_tab[d] : 4'hF;
            e_sseg = lit ? in_n[d]   : 8'hFF;
            e_fr   = (m_cnt == 0);
            m_cnt  = (m_cnt + 1) % C_FRAME;
        end
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("an_model",   {28'd0, an_n},   {28'd0, e_an});
            chk("sseg_model", {24'd0, sseg_n}, {24'd0, e_sseg});
            chk("frame_model",{31'd0, frame},  {31'd0, e_fr});
            chk("an_onehot",  32'($countones(~an_n) <= 1), 32'd1);
            chk("dark_blank", 32'((an_n != 4'hF) || (sseg_n == 8'hFF)), 32'd1);
        end
    end

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 2 * C_FRAME; i++) begin
            @(negedge clk);
            if (m_cnt == v) return;
        end
        total++;
        bad++;
        $display("FAIL wait_cnt: timed out waiting for count %0d (now %0d)", v, m_cnt);
    endtask

    // Counts lit cycles per digit slot over one aligned frame.
    task automatic count_frame(input string name, input int exp_slot);
        int lit_cnt [4];
        wait_cnt(0);
        for (int s = 0; s < 4; s++) lit_cnt[s] = 0;
        for (int i = 0; i < C_FRAME; i++) begin
            @(negedge clk);
            if (an_n != 4'hF) lit_cnt[i / C_SLOT]++;
        end
        for (int s = 0; s < 4; s++) chk(name, lit_cnt[s], (exp_slot >> (8 * s)) & 8'hFF);
    endtask

    initial begin
        rst    = 1'b1;
        dig_en = 4'hF;
        duty   = 4'hF;
        in_n[0] = 8'hC0; in_n[1] = 8'h99; in_n[2] = 8'hB0; in_n[3] = 8'hA4;

        // Reset held while inputs toggle: outputs stay blank.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_n[i % 4] = 8'($urandom);
            dig_en      = 4'($urandom);
            duty        = 4'($urandom);
            chk("rst_an", {28'd0, an_n}, 32'hF);
            chk("rst_sseg", {24'd0, sseg_n}, 32'hFF);
            chk("rst_frame", {31'd0, frame}, 32'd0);
        end
        in_n[0] = 8'hC0; in_n[1] = 8'h99; in_n[2] = 8'hB0; in_n[3] = 8'hA4;
        dig_en = 4'hF;
        duty   = 4'hF;
        @(negedge clk);
        rst = 1'b0;

        // Full brightness scan order.
        @(negedge clk);
        chk("lit_frame0", {31'd0, frame}, 32'd1);
        chk("lit_an0",    {28'd0, an_n}, 32'hE);
        chk("lit_sseg0",  {24'd0, sseg_n}, 32'hC0);
        @(negedge clk);
        chk("lit_frame1", {31'd0, frame}, 32'd0);
        repeat (63) @(negedge clk);
        chk("lit_an1",   {28'd0, an_n}, 32'hD);
        chk("lit_sseg1", {24'd0, sseg_n}, 32'h99);
        repeat (64) @(negedge clk);
        chk("lit_an2",   {28'd0, an_n}, 32'hB);
        chk("lit_sseg2", {24'd0, sseg_n}, 32'hB0);
        repeat (64) @(negedge clk);
        chk("lit_an3",   {28'd0, an_n}, 32'h7);
        chk("lit_sseg3", {24'd0, sseg_n}, 32'hA4);
        repeat (64) @(negedge clk);
        chk("lit_frame_wrap", {31'd0, frame}, 32'd1);

        // PWM: duty 4 gives 16 lit clocks per 64-clock slot; duty 0 is dark.
        duty = 4'd4;
        count_frame("duty4_slot", 32'h10101010);
        duty = 4'd0;
        count_frame("duty0_slot", 32'h00000000);
        duty = 4'd15;
        count_frame("duty15_slot", 32'h40404040);

        // Per-digit enable.
        dig_en = 4'b0101;
        count_frame("en0101_slot", 32'h00400040);
        dig_en = 4'hF;

        // Mid-slot pattern change on digit 1 at slot clock 20.
        in_n[1] = 8'hC0;
        wait_cnt(C_SLOT + 20);
        chk("mid_before_sseg", {24'd0, sseg_n}, 32'hC0);
        in_n[1] = 8'hF9;
        @(negedge clk);
        chk("mid_after_sseg", {24'd0, sseg_n}, 32'hF9);
        chk("mid_after_an",   {28'd0, an_n}, 32'hD);

        // Asynchronous reset between edges.
        wait_cnt(100);
        chk("pre_rst_an", {28'd0, an_n}, 32'hD);
        #2 rst = 1'b1;
        #1;
        chk("async_an",   {28'd0, an_n}, 32'hF);
        chk("async_sseg", {24'd0, sseg_n}, 32'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_frame", {31'd0, frame}, 32'd1);
        chk("rel_an",    {28'd0, an_n}, 32'hE);

        // Randomized inputs, checked every cycle against the model.
        for (int i = 0; i < 6 * C_FRAME; i++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) in_n[$urandom_range(3)] = 8'($urandom);
            if ($urandom_range(63) == 0) dig_en = 4'($urandom);
            if ($urandom_range(63) == 0) duty = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
